// File: rtl/q2_lcd.sv
// HD44780 8-bit display port: CPU write capture, FIFO, init and timing FSM.
// One bus address; commands and data are decoded from the 12-bit write word.
module q2_lcd #(
    parameter logic [11:0] ADDR      = 12'hFFF,
    parameter int          DEPTH     = 4,
    parameter int          E_CYCLES  = 2,
    parameter int          CMD_WAIT  = 4,
    parameter int          CLR_WAIT  = 16,
    parameter int          INIT_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] abus,
    input  logic [11:0] dbus,
    input  logic        wrm,
    output logic        lcd_rs,
    output logic        lcd_e,
    output logic [7:0]  lcd_d,
    output logic        busy,
    output logic        overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        INIT_DLY, INIT, IDLE, SETUP, PULSE, WAIT
    } state_t;

    state_t         state;
    logic [15:0]    cnt;
    logic [1:0]     step;
    logic           init_mode;
    logic           wrm_q;
    logic           hit;
    logic           push;
    logic           in_rs;
    logic [7:0]     in_d;
    logic [8:0]     mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic           wr;
    logic           pop;
    logic [7:0]     init_cmd;
    logic [15:0]    wait_last;
    logic           unused;

    assign unused = ^dbus[11:9];
    assign hit    = wrm && !wrm_q && (abus == ADDR);

    always_comb begin
        push  = 1'b0;
        in_rs = 1'b0;
        in_d  = 8'h00;
        if (dbus[8]) begin
            if (dbus[7]) begin
                push = hit;
                in_d = {1'b1, dbus[6:0]};
            end else if (dbus[0]) begin
                push = hit;
                in_d = 8'h01;
            end
        end else begin
            push  = hit;
            in_rs = 1'b1;
            // Non-printable characters are shown as '?'
            if (dbus[7:0] >= 8'h20 && dbus[7:0] <= 8'h7E)
                in_d = dbus[7:0];
            else
                in_d = 8'h3F;
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr    = push && !full;
    assign pop   = (state == IDLE) && !empty;
    assign busy  = !((state == IDLE) && empty);

    always_comb begin
        unique case (step)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    end

    assign wait_last = (!lcd_rs && lcd_d == 8'h01) ?
                       16'(CLR_WAIT - 1) : 16'(CMD_WAIT - 1);

    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= {in_rs, in_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrm_q    <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wrm_q <= wrm;
            if (wr)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (wr && !pop)
                count <= count + 1'b1;
            else if (pop && !wr)
                count <= count - 1'b1;
            if (push && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT_DLY;
            cnt       <= '0;
            step      <= '0;
            init_mode <= 1'b1;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_d     <= 8'h00;
        end else begin
            unique case (state)
                INIT_DLY: begin
                    if (cnt == 16'(INIT_WAIT - 1)) begin
                        cnt   <= '0;
                        state <= INIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT: begin
                    lcd_rs <= 1'b0;
                    lcd_d  <= init_cmd;
                    state  <= SETUP;
                end
                IDLE: begin
                    if (!empty) begin
                        lcd_rs <= mem[rp][8];
                        lcd_d  <= mem[rp][7:0];
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    lcd_e <= 1'b1;
                    cnt   <= '0;
                    state <= PULSE;
                end
                PULSE: begin
                    if (cnt == 16'(E_CYCLES - 1)) begin
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (init_mode && step != 2'd3) begin
                            step  <= step + 1'b1;
                            state <= INIT;
                        end else begin
                            init_mode <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= INIT_DLY;
            endcase
        end
    end
endmodule
